param_sweep_seq: RTL and testbench
==================================

PARAM_SWEEP_SEQ -- requirements
Module: param_sweep_seq

Interface
REQ-001 Parameters SHALL be: DW, default 32, width of delay values. CW, default 16, width of step and average counters.
REQ-002 Port clk_pll SHALL be an input, 1 bit: PLL clock, and the only clock of the block.
REQ-003 Port resetn SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-004 Port cfg_load SHALL be an input, 1 bit: single-cycle strobe that marks the cfg_* inputs valid.
REQ-005 Port cfg_del_start SHALL be an input, DW bits: first delay value of the sweep.
REQ-006 Port cfg_del_step SHALL be an input, DW bits: unsigned delay increment per step.
REQ-007 Port cfg_nsteps SHALL be an input, CW bits: number of delay points in the sweep.
REQ-008 Port cfg_navg SHALL be an input, CW bits: number of pulse periods per delay point.
REQ-009 Port cfg_repeat SHALL be an input, 1 bit: 1 means restart the sweep after the last point; 0 means a single sweep.
REQ-010 Port start SHALL be an input, 1 bit: strobe that begins a sweep.
REQ-011 Port abort SHALL be an input, 1 bit: strobe that cancels a sweep.
REQ-012 Port sync_in SHALL be an input, 1 bit: period SYNC level from the pulse generator.
REQ-013 Port del_out SHALL be an output, DW bits: delay value fed to the pulse generator.
REQ-014 Port step_idx SHALL be an output, CW bits: index of the current delay point.
REQ-015 Port active SHALL be an output, 1 bit: high while in ARMED or RUN.
REQ-016 Port done SHALL be an output, 1 bit: one-cycle pulse when a single sweep completes.
REQ-017 Port err SHALL be an output, 1 bit: one-cycle pulse when a request is rejected or the delay saturates.
REQ-018 All inputs SHALL be synchronous to clk_pll; any crossing from the 12 MHz control clock happens outside this block.

Function
REQ-019 The block SHALL have four states: IDLE, ARMED, RUN and DONE.
REQ-020 In IDLE or DONE, cfg_load SHALL copy all cfg_* inputs into shadow registers on the same edge.
REQ-021 In ARMED or RUN, cfg_load SHALL be ignored, the shadows SHALL stay unchanged, and err SHALL pulse.
REQ-022 start in IDLE or DONE SHALL move the block to ARMED, provided shadow nsteps is nonzero and shadow navg is nonzero.
REQ-023 If start in IDLE or DONE sees nsteps=0 or navg=0, the block SHALL stay in its state and pulse err.
REQ-024 If cfg_load and start arrive in the same cycle, the load SHALL occur and start SHALL be evaluated against the newly loaded values.
REQ-025 A sync edge SHALL be defined as a rising edge of sync_in, detected with one register, so the edge flag asserts one cycle after sync_in rises.
REQ-026 On entry to ARMED: del_out SHALL equal shadow del_start, step_idx=0 and avg_cnt=0.
REQ-027 ARMED SHALL move to RUN on the first sync edge, and that edge SHALL not count as an average.
REQ-028 On each sync edge in RUN, avg_cnt SHALL increment.
REQ-029 When avg_cnt==navg-1 at a sync edge in RUN, avg_cnt SHALL clear and the step rules below SHALL apply.
REQ-030 Step rule, step_idx < nsteps-1: step_idx SHALL increment and del_out SHALL become del_out+del_step.
REQ-031 Step rule, step_idx == nsteps-1 with repeat=1: step_idx SHALL become 0, del_out SHALL become del_start, and the block SHALL stay in RUN.
REQ-032 Step rule, step_idx == nsteps-1 with repeat=0: the block SHALL go to DONE, done SHALL pulse, and del_out SHALL become del_start.
REQ-033 del_out SHALL update exactly one clk_pll cycle after the edge flag, which is two cycles after sync_in rises.
REQ-034 del_out SHALL never change at any other time in RUN.
REQ-035 The delay addition SHALL be unsigned and saturate at 2^DW-1; on saturation, err SHALL pulse once and the sweep SHALL continue.
REQ-036 abort in any state SHALL send the block to IDLE on the next edge, with del_out=shadow del_start, step_idx=0 and avg_cnt=0.
REQ-037 abort SHALL take priority over start, cfg_load and a sync edge arriving in the same cycle.
REQ-038 A start received in ARMED or RUN SHALL be ignored without err.
REQ-039 The block SHALL stay in DONE until start, cfg_load or abort.
REQ-040 The active output SHALL be a registered decode of the state.

Reset
REQ-041 resetn low SHALL asynchronously force state=IDLE and clear all shadows, counters and the edge register.
REQ-042 During reset, del_out, step_idx, active, done and err SHALL all be 0.
REQ-043 Reset asserted mid-sweep SHALL abandon the sweep; after release, the block SHALL require cfg_load and start again.

Structure
REQ-044 Package sweep_pkg SHALL hold the state enum, DW/CW defaults and the saturation constant.
REQ-045 The saturating adder SHALL be the sub-module sweep_sat_add (inputs a, b; outputs sum, ovf).
REQ-046 The edge detector, FSM and counters SHALL stay in the top-level module.

Verification
REQ-047 Single sweep: load start=100, step=10, nsteps=3, navg=2, repeat=0, then start, then 7 sync pulses. Required: del_out=100,100,110,110,120,120 across the counted periods, then done pulses once, del_out=100, state DONE.
REQ-048 Repeat: same config with repeat=1 and 13 sync pulses. Required: step_idx sequence 0,0,1,1,2,2,0,0,1,1,2,2 and no done pulse.
REQ-049 Illegal requests: nsteps=0 then start -> err pulses and state stays IDLE. cfg_load during RUN -> err pulses and shadow values are unchanged.
REQ-050 Abort collision: abort in the same cycle as a sync-edge step -> IDLE next cycle, del_out=del_start, no increment.
REQ-051 Saturation: start=0xFFFFFFF0, step=0x20, nsteps=2, navg=1 -> second point del_out=0xFFFFFFFF with a single err pulse.
REQ-052 Reset mid-RUN: assert resetn low mid-RUN -> all outputs 0 immediately; a later start without cfg_load -> err and remain IDLE.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared definitions for the delay-sweep sequencer.
//   DW_DEF / CW_DEF : default delay and counter widths
//   SAT_MAX         : saturation value of a default-width delay
//   sweep_state_e   : sequencer state encoding
package sweep_pkg;
  localparam int DW_DEF = 32;
  localparam int CW_DEF = 16;
  localparam logic [DW_DEF-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;
endpackage

// File: rtl/sweep_sat_add.sv
// Unsigned saturating adder for the delay value.
//   a, b : operands
//   sum  : a+b, clamped to all-ones when the carry-out is set
//   ovf  : carry-out, i.e. the result was clamped
module sweep_sat_add
  import sweep_pkg::*;
#(
  parameter int W = DW_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};
  assign ovf = raw[W];
  assign sum = ovf ? {W{1'b1}} : raw[W-1:0];
endmodule

// File: rtl/param_sweep_seq.sv
// Delay-sweep sequencer for a pulse generator. Steps a delay value through
// nsteps points, holding each point for navg SYNC periods, optionally looping.
//   clk_pll, resetn       : clock, async active-low reset
//   cfg_load, cfg_*       : config strobe and values (shadowed in IDLE/DONE)
//   start, abort          : sweep control strobes
//   sync_in               : SYNC level from the pulse generator
//   del_out, step_idx     : current delay and point index
//   active, done, err     : status (done/err are one-cycle pulses)
module param_sweep_seq
  import sweep_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk_pll,
  input  logic          resetn,
  input  logic          cfg_load,
  input  logic [DW-1:0] cfg_del_start,
  input  logic [DW-1:0] cfg_del_step,
  input  logic [CW-1:0] cfg_nsteps,
  input  logic [CW-1:0] cfg_navg,
  input  logic          cfg_repeat,
  input  logic          start,
  input  logic          abort,
  input  logic          sync_in,
  output logic [DW-1:0] del_out,
  output logic [CW-1:0] step_idx,
  output logic          active,
  output logic          done,
  output logic          err
);
  sweep_state_e  state;
  logic [DW-1:0] sh_start, sh_step;
  logic [CW-1:0] sh_nsteps, sh_navg, avg_cnt;
  logic          sh_repeat;
  logic          sync_q, edge_q;
  logic [DW-1:0] add_sum;
  logic          add_ovf;

  // Registered rising-edge flag: high the cycle after sync_in is first seen high.
  always_ff @(posedge clk_pll or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_in;
      edge_q <= sync_in & ~sync_q;
    end
  end

  sweep_sat_add #(.W(DW)) u_add (
    .a   (del_out),
    .b   (sh_step),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // A load in the same cycle as start is visible to the start check.
  logic [DW-1:0] eff_start;
  logic [CW-1:0] eff_nsteps, eff_navg;
  logic          last_avg, last_step;

  assign eff_start  = cfg_load ? cfg_del_start : sh_start;
  assign eff_nsteps = cfg_load ? cfg_nsteps    : sh_nsteps;
  assign eff_navg   = cfg_load ? cfg_navg      : sh_navg;
  // Only evaluated in RUN, where nsteps and navg are known nonzero.
  assign last_avg   = (avg_cnt  == sh_navg   - CW'(1));
  assign last_step  = (step_idx == sh_nsteps - CW'(1));

  always_ff @(posedge clk_pll or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      sh_start  <= '0;
      sh_step   <= '0;
      sh_nsteps <= '0;
      sh_navg   <= '0;
      sh_repeat <= 1'b0;
      avg_cnt   <= '0;
      del_out   <= '0;
      step_idx  <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        active   <= 1'b0;
        del_out  <= sh_start;
        step_idx <= '0;
        avg_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (cfg_load) begin
              sh_start  <= cfg_del_start;
              sh_step   <= cfg_del_step;
              sh_nsteps <= cfg_nsteps;
              sh_navg   <= cfg_navg;
              sh_repeat <= cfg_repeat;
            end
            if (start) begin
              if (eff_nsteps != '0 && eff_navg != '0) begin
                state    <= ST_ARMED;
                active   <= 1'b1;
                del_out  <= eff_start;
                step_idx <= '0;
                avg_cnt  <= '0;
              end else begin
                err <= 1'b1;
                // A rejected start leaves the state alone, but a load still
                // retires a finished sweep.
                if (cfg_load) state <= ST_IDLE;
              end
            end else if (cfg_load) begin
              state <= ST_IDLE;
            end
          end
          ST_ARMED: begin
            if (cfg_load) err <= 1'b1;
            // First edge only aligns to the SYNC period; it is not averaged.
            if (edge_q) state <= ST_RUN;
          end
          ST_RUN: begin
            if (cfg_load) err <= 1'b1;
            if (edge_q) begin
              if (!last_avg) begin
                avg_cnt <= avg_cnt + CW'(1);
              end else begin
                avg_cnt <= '0;
                if (!last_step) begin
                  step_idx <= step_idx + CW'(1);
                  del_out  <= add_sum;
                  if (add_ovf) err <= 1'b1;
                end else if (sh_repeat) begin
                  step_idx <= '0;
                  del_out  <= sh_start;
                end else begin
                  state    <= ST_DONE;
                  active   <= 1'b0;
                  done     <= 1'b1;
                  step_idx <= '0;
                  del_out  <= sh_start;
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_param_sweep_seq.sv
module tb_param_sweep_seq;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic          clk_pll = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_load = 1'b0;
  logic [DW-1:0] cfg_del_start = '0;
  logic [DW-1:0] cfg_del_step = '0;
  logic [CW-1:0] cfg_nsteps = '0;
  logic [CW-1:0] cfg_navg = '0;
  logic          cfg_repeat = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sync_in = 1'b0;
  logic [DW-1:0] del_out;
  logic [CW-1:0] step_idx;
  logic          active, done, err;

  param_sweep_seq #(.DW(DW), .CW(CW)) dut (
    .clk_pll(clk_pll), .resetn(resetn), .cfg_load(cfg_load),
    .cfg_del_start(cfg_del_start), .cfg_del_step(cfg_del_step),
    .cfg_nsteps(cfg_nsteps), .cfg_navg(cfg_navg), .cfg_repeat(cfg_repeat),
    .start(start), .abort(abort), .sync_in(sync_in),
    .del_out(del_out), .step_idx(step_idx), .active(active),
    .done(done), .err(err)
  );

  always #5 clk_pll = ~clk_pll;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk_pll) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pll);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] st, input logic [DW-1:0] sp,
                      input int ns, input int na, input bit rep);
    cfg_del_start = st; cfg_del_step = sp;
    cfg_nsteps = CW'(ns); cfg_navg = CW'(na); cfg_repeat = rep;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic sync_pulse();
    int h, l;
    h = $urandom_range(1, 3);
    l = $urandom_range(2, 4);
    sync_in = 1'b1;
    repeat (h) tick();
    sync_in = 1'b0;
    repeat (l) tick();
  endtask

  // Expected point after c counted SYNC periods: the sweep position is just
  // floor(c/navg) points in, wrapped or finished depending on repeat.
  function automatic void model(input longint unsigned st, input longint unsigned sp,
                                input int ns, input int na, input bit rep, input int c,
                                output longint unsigned dv, output int idx, output bit fin);
    int t;
    t = c / na;
    fin = (!rep && t >= ns);
    if (fin) begin
      dv = st; idx = 0;
    end else begin
      idx = t % ns;
      dv = st + longint'(idx) * sp;
      if (dv > MAXV) dv = MAXV;
    end
  endfunction

  // Saturation errors: each forward step whose ideal value exceeds the range.
  function automatic int model_errs(input longint unsigned st, input longint unsigned sp,
                                    input int ns, input int na, input bit rep, input int c);
    int t_end, e, p;
    t_end = c / na;
    if (!rep && t_end > ns) t_end = ns;
    e = 0;
    for (int t = 1; t <= t_end; t++) begin
      p = t % ns;
      if (p != 0 && st + longint'(p) * sp > MAXV) e++;
    end
    return e;
  endfunction

  task automatic run_sweep(input string tag, input logic [DW-1:0] st, input logic [DW-1:0] sp,
                           input int ns, input int na, input bit rep, input int npulses);
    longint unsigned dv;
    int idx;
    bit fin;
    do_abort();
    load(st, sp, ns, na, rep);
    do_start();
    done_cnt = 0; err_cnt = 0;
    chk({tag, ".armed_active"}, 64'(active), 64'd1);
    sync_pulse();
    chk({tag, ".arm_del"}, 64'(del_out), 64'(st));
    for (int c = 1; c <= npulses; c++) begin
      sync_pulse();
      model(st, sp, ns, na, rep, c, dv, idx, fin);
      chk($sformatf("%s.del[%0d]", tag, c), 64'(del_out), dv);
      chk($sformatf("%s.idx[%0d]", tag, c), 64'(step_idx), 64'(idx));
      chk($sformatf("%s.act[%0d]", tag, c), 64'(active), 64'(!fin));
    end
    model(st, sp, ns, na, rep, npulses, dv, idx, fin);
    chk({tag, ".done_cnt"}, 64'(done_cnt), 64'(fin ? 1 : 0));
    chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(model_errs(st, sp, ns, na, rep, npulses)));
  endtask

  initial begin
    longint unsigned rst;
    longint unsigned rsp;
    int rns, rna, rnp;
    bit rrep;

    // Reset state
    #2;
    chk("rst.del", 64'(del_out), 64'd0);
    chk("rst.idx", 64'(step_idx), 64'd0);
    chk("rst.act", 64'(active), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    // Single sweep and repeat sweep
    run_sweep("single", 32'd100, 32'd10, 3, 2, 1'b0, 6);
    run_sweep("repeat", 32'd100, 32'd10, 3, 2, 1'b1, 12);

    // Illegal start: nsteps=0 and navg=0
    do_abort();
    load(32'd5, 32'd1, 0, 2, 1'b0);
    err_cnt = 0;
    do_start();
    tick();
    chk("ns0.err", 64'(err_cnt), 64'd1);
    chk("ns0.act", 64'(active), 64'd0);
    load(32'd5, 32'd1, 2, 0, 1'b0);
    err_cnt = 0;
    do_start();
    tick();
    chk("na0.err", 64'(err_cnt), 64'd1);
    chk("na0.act", 64'(active), 64'd0);

    // cfg_load during RUN is rejected and shadows are kept
    do_abort();
    load(32'd200, 32'd5, 3, 1, 1'b0);
    do_start();
    sync_pulse();
    sync_pulse();
    chk("ldrun.del1", 64'(del_out), 64'd205);
    err_cnt = 0; done_cnt = 0;
    load(32'd0, 32'd1, 9, 9, 1'b1);
    tick();
    chk("ldrun.err", 64'(err_cnt), 64'd1);
    sync_pulse();
    chk("ldrun.del2", 64'(del_out), 64'd210);
    sync_pulse();
    chk("ldrun.done", 64'(done_cnt), 64'd1);
    chk("ldrun.del3", 64'(del_out), 64'd200);

    // Start in RUN is ignored without err
    do_abort();
    load(32'd40, 32'd3, 4, 1, 1'b0);
    do_start();
    sync_pulse();
    err_cnt = 0;
    do_start();
    tick();
    chk("strun.err", 64'(err_cnt), 64'd0);
    chk("strun.act", 64'(active), 64'd1);

    // Abort collides with a stepping sync edge
    do_abort();
    load(32'd500, 32'd7, 4, 1, 1'b0);
    do_start();
    sync_pulse();
    sync_pulse();
    chk("abort.pre", 64'(del_out), 64'd507);
    sync_in = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sync_in = 1'b0;
    chk("abort.act", 64'(active), 64'd0);
    chk("abort.del", 64'(del_out), 64'd500);
    chk("abort.idx", 64'(step_idx), 64'd0);
    repeat (3) tick();
    chk("abort.hold", 64'(del_out), 64'd500);

    // Saturation
    run_sweep("sat", 32'hFFFF_FFF0, 32'h20, 2, 1, 1'b0, 2);
    do_abort();
    load(32'hFFFF_FFF0, 32'h20, 2, 1, 1'b0);
    do_start();
    sync_pulse();
    sync_pulse();
    chk("sat.pt2", 64'(del_out), 64'hFFFF_FFFF);

    // Reset mid-RUN
    do_abort();
    load(32'd77, 32'd4, 4, 2, 1'b1);
    do_start();
    repeat (3) sync_pulse();
    resetn = 1'b0;
    #1;
    chk("rrun.del", 64'(del_out), 64'd0);
    chk("rrun.idx", 64'(step_idx), 64'd0);
    chk("rrun.act", 64'(active), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    err_cnt = 0;
    do_start();
    tick();
    chk("rrun.err", 64'(err_cnt), 64'd1);
    chk("rrun.idle", 64'(active), 64'd0);

    // Randomized sweeps
    for (int k = 0; k < 8; k++) begin
      rst  = (k % 3 == 0) ? (MAXV - longint'($urandom_range(0, 600))) : longint'($urandom);
      rsp  = (k % 2 == 0) ? longint'($urandom_range(0, 300)) : longint'($urandom);
      rns  = $urandom_range(1, 4);
      rna  = $urandom_range(1, 3);
      rrep = 1'($urandom_range(0, 1));
      rnp  = $urandom_range(1, rns * rna * 2 + 1);
      run_sweep($sformatf("rnd%0d", k), DW'(rst), DW'(rsp), rns, rna, rrep, rnp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
